// File: rtl/bg_removal_pe.sv
// bg_removal_pe: two-pass background removal PE (per-channel pixel sums, then threshold-based replacement)
module bg_removal_pe #(
   parameter int num_pixels = 4
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Ack,
   input  logic [7:0]              red_exp,
   input  logic [7:0]              green_exp,
   input  logic [7:0]              blue_exp,
   input  logic [7:0]              threshold,
   input  logic [7:0]              desired_bg_r,
   input  logic [7:0]              desired_bg_g,
   input  logic [7:0]              desired_bg_b,
   input  logic                    Start_Sum,
   input  logic                    Start_BgRemoval,
   input  logic [8*num_pixels-1:0] red_in,
   input  logic [8*num_pixels-1:0] green_in,
   input  logic [8*num_pixels-1:0] blue_in,
   output logic [8*num_pixels-1:0] red_out,
   output logic [8*num_pixels-1:0] green_out,
   output logic [8*num_pixels-1:0] blue_out,
   output logic                    Qi,
   output logic                    Qbgi,
   output logic                    Qbg,
   output logic                    Qbgd,
   output logic                    Qsi,
   output logic                    Qs,
   output logic                    Qsd,
   output logic [8*num_pixels-1:0] red_sum,
   output logic [8*num_pixels-1:0] green_sum,
   output logic [8*num_pixels-1:0] blue_sum
);
   localparam int W = 8 * num_pixels;
   localparam int IW = num_pixels > 1 ? $clog2(num_pixels) : 1;
   localparam logic [IW-1:0] LAST = IW'(num_pixels - 1);
   typedef enum logic [2:0] {S_I, S_SI, S_S, S_SD, S_BGI, S_BG, S_BGD} state_t;
   state_t st_q, st_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0] rs_q, rs_d, gs_q, gs_d, bs_q, bs_d;
   logic [W-1:0] ro_q, ro_d, go_q, go_d, bo_q, bo_d;
   logic [7:0] er_q, er_d, eg_q, eg_d, eb_q, eb_d, th_q, th_d;
   logic [7:0] dr_q, dr_d, dg_q, dg_d, db_q, db_d;
   logic [7:0] pr, pg, pb;
   logic hit;
   function automatic logic [7:0] absd(input logic [7:0] a, input logic [7:0] b);
      return a > b ? a - b : b - a;
   endfunction
   assign pr = red_in[{idx_q, 3'b000} +: 8];
   assign pg = green_in[{idx_q, 3'b000} +: 8];
   assign pb = blue_in[{idx_q, 3'b000} +: 8];
   assign hit = absd(pr, er_q) <= th_q && absd(pg, eg_q) <= th_q && absd(pb, eb_q) <= th_q;
   always_comb begin
      st_d = st_q;
      case (st_q)
         S_I:          st_d = Start_Sum ? S_SI : Start_BgRemoval ? S_BGI : S_I;
         S_SI:         st_d = S_S;
         S_S:          st_d = idx_q == LAST ? S_SD : S_S;
         S_BGI:        st_d = S_BG;
         S_BG:         st_d = idx_q == LAST ? S_BGD : S_BG;
         S_SD, S_BGD:  st_d = Start_BgRemoval ? S_BGI : Start_Sum ? S_SI : Ack ? S_I : st_q;
         default:      st_d = S_I;
      endcase
   end
   always_comb begin
      idx_d = (st_q == S_SI || st_q == S_BGI) ? '0 : (st_q == S_S || st_q == S_BG) ? idx_q + IW'(1) : idx_q;
      rs_d = st_q == S_SI ? '0 : st_q == S_S ? rs_q + W'(pr) : rs_q;
      gs_d = st_q == S_SI ? '0 : st_q == S_S ? gs_q + W'(pg) : gs_q;
      bs_d = st_q == S_SI ? '0 : st_q == S_S ? bs_q + W'(pb) : bs_q;
      er_d = st_q == S_BGI ? red_exp : er_q;
      eg_d = st_q == S_BGI ? green_exp : eg_q;
      eb_d = st_q == S_BGI ? blue_exp : eb_q;
      th_d = st_q == S_BGI ? threshold : th_q;
      dr_d = st_q == S_BGI ? desired_bg_r : dr_q;
      dg_d = st_q == S_BGI ? desired_bg_g : dg_q;
      db_d = st_q == S_BGI ? desired_bg_b : db_q;
      ro_d = ro_q;
      go_d = go_q;
      bo_d = bo_q;
      if (st_q == S_BG) begin
         ro_d[{idx_q, 3'b000} +: 8] = hit ? dr_q : pr;
         go_d[{idx_q, 3'b000} +: 8] = hit ? dg_q : pg;
         bo_d[{idx_q, 3'b000} +: 8] = hit ? db_q : pb;
      end
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         st_q <= S_I;
         idx_q <= '0;
         {rs_q, gs_q, bs_q, ro_q, go_q, bo_q} <= '0;
         {er_q, eg_q, eb_q, th_q, dr_q, dg_q, db_q} <= '0;
      end else begin
         st_q <= st_d;
         idx_q <= idx_d;
         {rs_q, gs_q, bs_q, ro_q, go_q, bo_q} <= {rs_d, gs_d, bs_d, ro_d, go_d, bo_d};
         {er_q, eg_q, eb_q, th_q, dr_q, dg_q, db_q} <= {er_d, eg_d, eb_d, th_d, dr_d, dg_d, db_d};
      end
   end
   assign Qi = st_q == S_I;
   assign Qsi = st_q == S_SI;
   assign Qs = st_q == S_S;
   assign Qsd = st_q == S_SD;
   assign Qbgi = st_q == S_BGI;
   assign Qbg = st_q == S_BG;
   assign Qbgd = st_q == S_BGD;
   assign red_sum = rs_q;
   assign green_sum = gs_q;
   assign blue_sum = bs_q;
   assign red_out = ro_q;
   assign green_out = go_q;
   assign blue_out = bo_q;
endmodule

// File: tb/tb_bg_removal_pe.sv
// tb_bg_removal_pe: table-driven and randomized self-checking bench for bg_removal_pe
module tb_bg_removal_pe;
   localparam int NP = 4;
   typedef struct {
      logic [31:0] r, g, b;
      logic [7:0]  er, eg, eb, th, dr, dg, db;
      logic [31:0] xr, xg, xb;
   } vec_t;
   logic Clk = 1'b0;
   logic Reset, Ack, Start_Sum, Start_BgRemoval;
   logic [7:0] red_exp, green_exp, blue_exp, threshold, desired_bg_r, desired_bg_g, desired_bg_b;
   logic [31:0] red_in, green_in, blue_in, red_out, green_out, blue_out, red_sum, green_sum, blue_sum;
   logic Qi, Qbgi, Qbg, Qbgd, Qsi, Qs, Qsd;
   logic [6:0] flags;
   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl[3];
   bg_removal_pe #(.num_pixels(NP)) dut (
      .Clk(Clk), .Reset(Reset), .Ack(Ack),
      .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp), .threshold(threshold),
      .desired_bg_r(desired_bg_r), .desired_bg_g(desired_bg_g), .desired_bg_b(desired_bg_b),
      .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .Qi(Qi), .Qbgi(Qbgi), .Qbg(Qbg), .Qbgd(Qbgd), .Qsi(Qsi), .Qs(Qs), .Qsd(Qsd),
      .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum)
   );
   always #5 Clk = ~Clk;
   assign flags = {Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd};
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", nm, act, act, exp, exp);
      end
   endtask
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask
   function automatic logic [31:0] msum(input logic [31:0] p);
      int s = 0;
      for (int i = 0; i < NP; i++) s += int'(p[8*i +: 8]);
      return 32'(s);
   endfunction
   function automatic int adiff(input logic [7:0] a, input logic [7:0] b);
      int d = int'(a) - int'(b);
      return d < 0 ? -d : d;
   endfunction
   task automatic model_bg(inout vec_t v);
      for (int i = 0; i < NP; i++) begin
         if (adiff(v.r[8*i +: 8], v.er) <= int'(v.th) && adiff(v.g[8*i +: 8], v.eg) <= int'(v.th) &&
             adiff(v.b[8*i +: 8], v.eb) <= int'(v.th)) begin
            v.xr[8*i +: 8] = v.dr;
            v.xg[8*i +: 8] = v.dg;
            v.xb[8*i +: 8] = v.db;
         end else begin
            v.xr[8*i +: 8] = v.r[8*i +: 8];
            v.xg[8*i +: 8] = v.g[8*i +: 8];
            v.xb[8*i +: 8] = v.b[8*i +: 8];
         end
      end
   endtask
   task automatic run_sum(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b, input bit inj);
      int n;
      red_in = r; green_in = g; blue_in = b;
      Start_Sum = 1'b1;
      tick();
      Start_Sum = 1'b0;
      chk("sum_enter_qsi", 32'(flags), 32'h20);
      n = 1;
      while (!Qsd && n < 20) begin
         if (inj && n == 2) begin
            Start_Sum = 1'b1; Start_BgRemoval = 1'b1; Ack = 1'b1;
         end
         tick();
         Start_Sum = 1'b0; Start_BgRemoval = 1'b0; Ack = 1'b0;
         n++;
      end
      chk("sum_latency", 32'(n), 32'd6);
      chk("sum_red", red_sum, msum(r));
      chk("sum_green", green_sum, msum(g));
      chk("sum_blue", blue_sum, msum(b));
   endtask
   task automatic run_bg(input vec_t v, input string nm);
      int n;
      red_in = v.r; green_in = v.g; blue_in = v.b;
      red_exp = v.er; green_exp = v.eg; blue_exp = v.eb; threshold = v.th;
      desired_bg_r = v.dr; desired_bg_g = v.dg; desired_bg_b = v.db;
      Start_BgRemoval = 1'b1;
      tick();
      Start_BgRemoval = 1'b0;
      chk({nm, "_enter_qbgi"}, 32'(flags), 32'h04);
      n = 1;
      while (!Qbgd && n < 20) begin
         if (n == 2) begin
            red_exp = 8'($urandom); green_exp = 8'($urandom); blue_exp = 8'($urandom);
            threshold = 8'($urandom); desired_bg_r = 8'($urandom);
            desired_bg_g = 8'($urandom); desired_bg_b = 8'($urandom);
         end
         tick();
         n++;
      end
      chk({nm, "_latency"}, 32'(n), 32'd6);
      chk({nm, "_red"}, red_out, v.xr);
      chk({nm, "_green"}, green_out, v.xg);
      chk({nm, "_blue"}, blue_out, v.xb);
   endtask
   initial begin
      vec_t v;
      logic [31:0] r0, g0, b0;
      int n;
      r0 = {8'd61, 8'd61, 8'd61, 8'd204};
      g0 = {8'd133, 8'd133, 8'd133, 8'd0};
      b0 = {8'd198, 8'd198, 8'd198, 8'd0};
      tbl[0] = '{r0, g0, b0, 8'd96, 8'd99, 8'd148, 8'd60, 8'd106, 8'd168, 8'd79,
                 {8'd106, 8'd106, 8'd106, 8'd204}, {8'd168, 8'd168, 8'd168, 8'd0}, {8'd79, 8'd79, 8'd79, 8'd0}};
      tbl[1] = '{{8'd61, 8'd62, 8'd61, 8'd204}, {8'd133, 8'd133, 8'd133, 8'd0}, {8'd199, 8'd198, 8'd198, 8'd0},
                 8'd61, 8'd133, 8'd198, 8'd0, 8'd106, 8'd168, 8'd79,
                 {8'd61, 8'd62, 8'd106, 8'd204}, {8'd133, 8'd133, 8'd168, 8'd0}, {8'd199, 8'd198, 8'd79, 8'd0}};
      tbl[2] = '{r0, g0, b0, 8'd0, 8'd255, 8'd17, 8'd255, 8'd1, 8'd2, 8'd3,
                 32'h01010101, 32'h02020202, 32'h03030303};
      Reset = 1'b1; Ack = 1'b0; Start_Sum = 1'b0; Start_BgRemoval = 1'b0;
      red_exp = '0; green_exp = '0; blue_exp = '0; threshold = '0;
      desired_bg_r = '0; desired_bg_g = '0; desired_bg_b = '0;
      red_in = '0; green_in = '0; blue_in = '0;
      repeat (5) tick();
      Reset = 1'b0;
      chk("reset_flags", 32'(flags), 32'h40);
      chk("reset_sums", red_sum | green_sum | blue_sum, 32'd0);
      chk("reset_outs", red_out | green_out | blue_out, 32'd0);
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      chk("ack_in_idle", 32'(flags), 32'h40);
      run_sum(r0, g0, b0, 1'b0);
      chk("spec_red_sum", red_sum, 32'd387);
      chk("spec_green_sum", green_sum, 32'd399);
      chk("spec_blue_sum", blue_sum, 32'd594);
      tick(); tick();
      chk("qsd_hold_flags", 32'(flags), 32'h08);
      chk("qsd_hold_sum", red_sum, 32'd387);
      for (int k = 0; k < 3; k++) begin
         run_bg(tbl[k], $sformatf("tbl%0d", k));
         chk("sums_kept_in_bg", green_sum, 32'd399);
      end
      tick();
      chk("qbgd_hold_out", blue_out, 32'h03030303);
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      chk("ack_to_idle", 32'(flags), 32'h40);
      Start_Sum = 1'b1; Start_BgRemoval = 1'b1;
      tick();
      Start_Sum = 1'b0; Start_BgRemoval = 1'b0;
      chk("both_starts_qsi", 32'(flags), 32'h20);
      n = 0;
      while (!Qsd && n < 20) begin tick(); n++; end
      chk("both_starts_reach_qsd", 32'(Qsd), 32'd1);
      run_sum({8'd255, 8'd255, 8'd255, 8'd255}, {8'd0, 8'd1, 8'd2, 8'd3}, {8'd9, 8'd0, 8'd0, 8'd7}, 1'b1);
      chk("max_red_sum", red_sum, 32'd1020);
      for (int it = 0; it < 20; it++) begin
         v.er = 8'($urandom); v.eg = 8'($urandom); v.eb = 8'($urandom);
         for (int i = 0; i < NP; i++) begin
            v.r[8*i +: 8] = 8'(int'(v.er) + int'($urandom_range(0, 40)) - 20);
            v.g[8*i +: 8] = 8'(int'(v.eg) + int'($urandom_range(0, 40)) - 20);
            v.b[8*i +: 8] = 8'(int'(v.eb) + int'($urandom_range(0, 40)) - 20);
         end
         v.th = (it % 5 == 4) ? 8'($urandom) : 8'($urandom_range(0, 24));
         v.dr = 8'($urandom); v.dg = 8'($urandom); v.db = 8'($urandom);
         model_bg(v);
         run_sum(v.r, v.g, v.b, it[0]);
         run_bg(v, "rand");
      end
      Start_Sum = 1'b1;
      tick();
      Start_Sum = 1'b0;
      tick(); tick();
      chk("mid_qs_state", 32'(flags), 32'h10);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("mid_reset_flags", 32'(flags), 32'h40);
      chk("mid_reset_sums", red_sum | green_sum | blue_sum, 32'd0);
      chk("mid_reset_outs", red_out | green_out | blue_out, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
